trap_controller: RTL and testbench
==================================

Name: trap_controller

Overview:
- Sequences machine-mode trap entry and MRET return around the CSR register file and the rv32i pipeline.
- Samples enabled pending interrupts and arbitrates between interrupt sources and MRET requests.
- Drains the pipeline, then pulses trap-entry or MRET-commit to the CSR file.
- Drives a single PC redirect with a timed flush window. Sits between the decode/execute stages, the CSR file and the PC mux.

Parameters:
- FLUSH_CYCLES, 2: cycles flush stays high after redirect (>=1).
- DRAIN_TIMEOUT, 16: max cycles waiting for drain_done before abort (>=2).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- mstatus_mie  in  1  mstatus[3] from CSR file
- mie_bits  in  32  mie register (bits 3, 7, 11 used)
- sw_int / timer_int / ext_int  in  1 each  raw interrupt levels (MSIP, MTIP, MEIP)
- mtvec  in  32  trap vector register
- mepc  in  32  return address from CSR file
- mret_req  in  1  MRET decoded in execute, level, held until mret_commit
- drain_done  in  1  pipeline has no older instruction in flight
- next_pc  in  32  PC of oldest unretired instruction, valid when drain_done=1
- stall_fetch  out  1  hold fetch/decode
- trap_enter  out  1  1-cycle pulse: CSR file writes mepc/mcause and mstatus MPIE<=MIE, MIE<=0
- trap_cause  out  32  {1'b1, 27'b0, code}, valid with trap_enter
- trap_epc  out  32  next_pc latched at drain, valid with trap_enter
- mret_commit  out  1  1-cycle pulse: CSR file does MIE<=MPIE, MPIE<=1
- redirect_valid  out  1  1-cycle pulse to PC mux
- redirect_pc  out  32  target, valid with redirect_valid
- flush  out  1  squash IF/ID/EX
- drain_err  out  1  1-cycle pulse on drain timeout

Behaviour:
- Reset: state IDLE, counters 0. All outputs 0, including trap_cause, trap_epc and redirect_pc. Reset is honoured from any state; no pulse is emitted in the reset-release cycle.
- pend = mstatus_mie & |({ext_int,timer_int,sw_int} & {mie_bits[11],mie_bits[7],mie_bits[3]}).
- Priority fixed: ext (code 11) > sw (3) > timer (7).
- States: IDLE, DRAIN, ENTER, RET, FLUSH.
- IDLE:
  - If mret_req: go to DRAIN with kind=RET. mret_req wins over pend in the same cycle.
  - Else if pend: go to DRAIN with kind=INT.
  - stall_fetch=0.
- DRAIN:
  - stall_fetch=1. Counter increments each cycle.
  - On drain_done:
    - kind=INT with pend still true: latch cause (priority encode at this cycle) and trap_epc=next_pc & 32'hFFFF_FFFC, then go to ENTER.
    - kind=INT with pend now false: go to IDLE with no trap and no pulse.
    - kind=RET: go to RET.
  - If the counter reaches DRAIN_TIMEOUT without drain_done: pulse drain_err, go to IDLE.
- ENTER (1 cycle):
  - trap_enter=1, redirect_valid=1.
  - redirect_pc = {mtvec[31:2],2'b00}, or vectored (see feature).
  - Go to FLUSH.
- RET (1 cycle):
  - mret_commit=1, redirect_valid=1, redirect_pc = mepc & 32'hFFFF_FFFC.
  - Go to FLUSH.
- FLUSH:
  - flush=1 and stall_fetch=1 for exactly FLUSH_CYCLES cycles after the pulse cycle, then go to IDLE.
  - flush is also 1 during ENTER/RET.
  - Interrupts and mret_req are ignored until IDLE.
- Latency: a request in IDLE with drain_done already high gives trap_enter/mret_commit 2 cycles later. FLUSH_CYCLES+1 cycles after that, stall_fetch drops.
- Back-to-back: an interrupt pending when MRET completes is taken from IDLE on the next cycle. MRET restores MIE, so pend is evaluated with the updated mstatus_mie.
- Interrupt levels are not latched; a source dropping before drain_done cancels the trap.
- All address arithmetic is 32-bit and wraps modulo 2^32.

Optional Feature:
- TRAP_CTRL_VECTORED_EN defined: when mtvec[1:0]==2'b01, ENTER uses redirect_pc = {mtvec[31:2],2'b00} + (code<<2), e.g. timer +28, ext +44. mtvec[1:0]==00 gives direct mode.
- Undefined: mtvec[1:0] is ignored and every trap goes to {mtvec[31:2],2'b00}.

Test Plan:
- mtvec=0x100, mstatus_mie=1, mie_bits[7]=1, timer_int=1, drain_done=1, next_pc=0x2004 -> 2 cycles later: trap_enter=1, trap_cause=0x80000007, trap_epc=0x2004, redirect_pc=0x100; flush high 3 cycles total.
- ext_int, sw_int and timer_int all set and enabled -> trap_cause=0x8000000B. With TRAP_CTRL_VECTORED_EN and mtvec=0x101 -> redirect_pc=0x12C.
- mret_req and timer pending same cycle, mepc=0x2004 -> mret_commit first with redirect_pc=0x2004. After FLUSH, IDLE, then the timer trap is taken next.
- timer_int drops while in DRAIN before drain_done -> return to IDLE; no trap_enter, no redirect.
- drain_done held 0 for DRAIN_TIMEOUT=16 cycles -> drain_err pulse at cycle 16, stall_fetch=0 next cycle.
- reset asserted during FLUSH -> all outputs 0 immediately; after release, no stray pulse.

Source files
------------

// File: rtl/trap_controller_if.sv
// trap_controller_if: groups the CSR-side, pipeline-side and PC-mux-side
// signals of the machine-mode trap controller into one bundle.
// master = the trap controller, slave = the surrounding core / CSR file.
interface trap_controller_if;
    // CSR file and interrupt sources
    logic        mstatus_mie;
    logic [31:0] mie_bits;
    logic        sw_int;
    logic        timer_int;
    logic        ext_int;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    // pipeline
    logic        mret_req;
    logic        drain_done;
    logic [31:0] next_pc;
    // controller outputs
    logic        stall_fetch;
    logic        trap_enter;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic        mret_commit;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        drain_err;

    modport master (
        input  mstatus_mie, mie_bits, sw_int, timer_int, ext_int,
               mtvec, mepc, mret_req, drain_done, next_pc,
        output stall_fetch, trap_enter, trap_cause, trap_epc, mret_commit,
               redirect_valid, redirect_pc, flush, drain_err
    );

    modport slave (
        output mstatus_mie, mie_bits, sw_int, timer_int, ext_int,
               mtvec, mepc, mret_req, drain_done, next_pc,
        input  stall_fetch, trap_enter, trap_cause, trap_epc, mret_commit,
               redirect_valid, redirect_pc, flush, drain_err
    );
endinterface

// File: rtl/trap_controller.sv
// trap_controller: sequences machine-mode interrupt entry and MRET return.
// Arbitrates pending interrupts against MRET, waits for the pipeline to
// drain, pulses trap_enter / mret_commit to the CSR file and issues one PC
// redirect followed by a flush window of FLUSH_CYCLES cycles.
// Optional build macro: TRAP_CTRL_VECTORED_EN enables vectored mtvec mode
// (mtvec[1:0]==2'b01 -> base + 4*code); without it mtvec[1:0] is ignored.
module trap_controller #(
    parameter int FLUSH_CYCLES  = 2,   // flush cycles after the redirect pulse (>=1)
    parameter int DRAIN_TIMEOUT = 16   // DRAIN cycles before abort (>=2)
) (
    input  logic              clk,
    input  logic              reset,
    trap_controller_if.master bus
);

    localparam int CNT_MAX = (DRAIN_TIMEOUT > FLUSH_CYCLES) ? DRAIN_TIMEOUT : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, DRAIN, ENTER, RET, FLUSH} state_t;

    state_t             state_reg;
    logic               kind_ret_reg;   // 1: draining for MRET, 0: for an interrupt
    logic [CNT_W-1:0]   cnt_reg;

    logic               stall_fetch_reg;
    logic               trap_enter_reg;
    logic [31:0]        trap_cause_reg;
    logic [31:0]        trap_epc_reg;
    logic               mret_commit_reg;
    logic               redirect_valid_reg;
    logic [31:0]        redirect_pc_reg;
    logic               flush_reg;
    logic               drain_err_reg;

    // Raw sources and enables, ordered {ext, timer, sw}
    logic [2:0] int_raw;
    logic [2:0] int_en;
    logic [2:0] int_hit;
    logic       pend;
    logic [3:0] cause_code;
    logic [31:0] trap_base;
    logic [31:0] trap_target;

    assign int_raw = {bus.ext_int, bus.timer_int, bus.sw_int};
    assign int_en  = {bus.mie_bits[11], bus.mie_bits[7], bus.mie_bits[3]};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_mask
            assign int_hit[gi] = int_raw[gi] & int_en[gi];
        end
    endgenerate

    assign pend = bus.mstatus_mie & (|int_hit);

    // Fixed priority: external (11) > software (3) > timer (7)
    always_comb begin
        cause_code = 4'd0;
        if (int_hit[2])
            cause_code = 4'd11;
        else if (int_hit[0])
            cause_code = 4'd3;
        else if (int_hit[1])
            cause_code = 4'd7;
    end

    assign trap_base = {bus.mtvec[31:2], 2'b00};

    // Trap target: direct base, or base + 4*code in vectored mode
    always_comb begin
        trap_target = trap_base;
`ifdef TRAP_CTRL_VECTORED_EN
        if (bus.mtvec[1:0] == 2'b01)
            trap_target = trap_base + {26'd0, cause_code, 2'b00};
`endif
    end

    // Bits of the inputs that the controller deliberately never looks at
`ifdef TRAP_CTRL_VECTORED_EN
    logic unused_bits;
    assign unused_bits = ^{bus.mie_bits[31:12], bus.mie_bits[10:8], bus.mie_bits[6:4],
                           bus.mie_bits[2:0], bus.next_pc[1:0], bus.mepc[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{bus.mie_bits[31:12], bus.mie_bits[10:8], bus.mie_bits[6:4],
                           bus.mie_bits[2:0], bus.next_pc[1:0], bus.mepc[1:0],
                           bus.mtvec[1:0]};
`endif

    // Trap/return sequencer with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg          <= IDLE;
            kind_ret_reg       <= 1'b0;
            cnt_reg            <= '0;
            stall_fetch_reg    <= 1'b0;
            trap_enter_reg     <= 1'b0;
            trap_cause_reg     <= 32'd0;
            trap_epc_reg       <= 32'd0;
            mret_commit_reg    <= 1'b0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= 32'd0;
            flush_reg          <= 1'b0;
            drain_err_reg      <= 1'b0;
        end else begin
            // single-cycle pulses fall unless re-asserted below
            trap_enter_reg     <= 1'b0;
            mret_commit_reg    <= 1'b0;
            redirect_valid_reg <= 1'b0;
            drain_err_reg      <= 1'b0;

            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (bus.mret_req) begin
                        // MRET wins over a simultaneously pending interrupt
                        state_reg       <= DRAIN;
                        kind_ret_reg    <= 1'b1;
                        stall_fetch_reg <= 1'b1;
                    end else if (pend) begin
                        state_reg       <= DRAIN;
                        kind_ret_reg    <= 1'b0;
                        stall_fetch_reg <= 1'b1;
                    end
                end

                DRAIN: begin
                    if (drain_err_reg) begin
                        // Abort cycle: drain_err is already visible, so give
                        // up even if drain_done shows up in this very cycle.
                        state_reg       <= IDLE;
                        stall_fetch_reg <= 1'b0;
                        cnt_reg         <= '0;
                    end else if (bus.drain_done) begin
                        cnt_reg <= '0;
                        if (kind_ret_reg) begin
                            state_reg          <= RET;
                            mret_commit_reg    <= 1'b1;
                            redirect_valid_reg <= 1'b1;
                            redirect_pc_reg    <= {bus.mepc[31:2], 2'b00};
                            flush_reg          <= 1'b1;
                        end else if (pend) begin
                            state_reg          <= ENTER;
                            trap_enter_reg     <= 1'b1;
                            redirect_valid_reg <= 1'b1;
                            redirect_pc_reg    <= trap_target;
                            trap_cause_reg     <= {1'b1, 27'd0, cause_code};
                            trap_epc_reg       <= {bus.next_pc[31:2], 2'b00};
                            flush_reg          <= 1'b1;
                        end else begin
                            // source went away while draining: cancel quietly
                            state_reg       <= IDLE;
                            stall_fetch_reg <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                        // raise drain_err so it lands in the last DRAIN cycle
                        if (cnt_reg == CNT_W'(DRAIN_TIMEOUT - 2))
                            drain_err_reg <= 1'b1;
                    end
                end

                ENTER, RET: begin
                    state_reg <= FLUSH;
                    cnt_reg   <= '0;
                end

                FLUSH: begin
                    if (cnt_reg == CNT_W'(FLUSH_CYCLES - 1)) begin
                        state_reg       <= IDLE;
                        flush_reg       <= 1'b0;
                        stall_fetch_reg <= 1'b0;
                        cnt_reg         <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg       <= IDLE;
                    flush_reg       <= 1'b0;
                    stall_fetch_reg <= 1'b0;
                    cnt_reg         <= '0;
                end
            endcase
        end
    end

    assign bus.stall_fetch    = stall_fetch_reg;
    assign bus.trap_enter     = trap_enter_reg;
    assign bus.trap_cause     = trap_cause_reg;
    assign bus.trap_epc       = trap_epc_reg;
    assign bus.mret_commit    = mret_commit_reg;
    assign bus.redirect_valid = redirect_valid_reg;
    assign bus.redirect_pc    = redirect_pc_reg;
    assign bus.flush          = flush_reg;
    assign bus.drain_err      = drain_err_reg;

endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed bench for trap_controller with
// FLUSH_CYCLES=2 and DRAIN_TIMEOUT=16. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
module tb_trap_controller;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [31:0] exp_vec_pc;

    trap_controller_if bus ();

    trap_controller #(
        .FLUSH_CYCLES  (2),
        .DRAIN_TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk32({tag, "_ctrl"}, {26'd0, bus.stall_fetch, bus.trap_enter, bus.mret_commit,
                               bus.redirect_valid, bus.flush, bus.drain_err}, 32'd0);
        chk32({tag, "_cause"}, bus.trap_cause, 32'd0);
        chk32({tag, "_epc"}, bus.trap_epc, 32'd0);
        chk32({tag, "_rpc"}, bus.redirect_pc, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
`ifdef TRAP_CTRL_VECTORED_EN
        exp_vec_pc = 32'h0000_012C;
`else
        exp_vec_pc = 32'h0000_0100;
`endif
        reset           = 1'b1;
        bus.mstatus_mie = 1'b0;
        bus.mie_bits    = 32'd0;
        bus.sw_int      = 1'b0;
        bus.timer_int   = 1'b0;
        bus.ext_int     = 1'b0;
        bus.mtvec       = 32'd0;
        bus.mepc        = 32'd0;
        bus.mret_req    = 1'b0;
        bus.drain_done  = 1'b0;
        bus.next_pc     = 32'd0;

        // ---- reset state ----
        step();
        step();
        chk_all_zero("rst");
        reset = 1'b0;
        step();
        chk_all_zero("rel");
        $display("txn reset: checked idle outputs");

        // ---- timer trap, drain already done ----
        bus.mtvec       = 32'h0000_0100;
        bus.mstatus_mie = 1'b1;
        bus.mie_bits    = 32'h0000_0888;
        bus.timer_int   = 1'b1;
        bus.drain_done  = 1'b1;
        bus.next_pc     = 32'h0000_2004;
        step();
        chk1("t1_drain_stall", bus.stall_fetch, 1'b1);
        chk1("t1_drain_te", bus.trap_enter, 1'b0);
        step();
        chk1("t1_te", bus.trap_enter, 1'b1);
        chk32("t1_cause", bus.trap_cause, 32'h8000_0007);
        chk32("t1_epc", bus.trap_epc, 32'h0000_2004);
        chk1("t1_rv", bus.redirect_valid, 1'b1);
        chk32("t1_rpc", bus.redirect_pc, 32'h0000_0100);
        chk1("t1_flush0", bus.flush, 1'b1);
        bus.timer_int = 1'b0;
        step();
        chk1("t1_te_drop", bus.trap_enter, 1'b0);
        chk1("t1_rv_drop", bus.redirect_valid, 1'b0);
        chk1("t1_flush1", bus.flush, 1'b1);
        step();
        chk1("t1_flush2", bus.flush, 1'b1);
        chk1("t1_stall2", bus.stall_fetch, 1'b1);
        step();
        chk1("t1_flush_end", bus.flush, 1'b0);
        chk1("t1_stall_end", bus.stall_fetch, 1'b0);
        $display("txn timer trap: cause=%h epc=%h", bus.trap_cause, bus.trap_epc);

        // ---- all three sources: ext wins; mtvec low bits 01 ----
        bus.mtvec     = 32'h0000_0101;
        bus.next_pc   = 32'h0000_3003;
        bus.ext_int   = 1'b1;
        bus.sw_int    = 1'b1;
        bus.timer_int = 1'b1;
        step();
        step();
        chk1("t2_te", bus.trap_enter, 1'b1);
        chk32("t2_cause", bus.trap_cause, 32'h8000_000B);
        chk32("t2_epc", bus.trap_epc, 32'h0000_3000);
        chk32("t2_rpc", bus.redirect_pc, exp_vec_pc);
        bus.ext_int   = 1'b0;
        bus.sw_int    = 1'b0;
        bus.timer_int = 1'b0;
        step();
        step();
        step();
        chk1("t2_stall_end", bus.stall_fetch, 1'b0);
        $display("txn ext trap: cause=%h rpc=%h", bus.trap_cause, bus.redirect_pc);

        // ---- sw beats timer ----
        bus.mtvec     = 32'h0000_0200;
        bus.sw_int    = 1'b1;
        bus.timer_int = 1'b1;
        step();
        step();
        chk1("t3_te", bus.trap_enter, 1'b1);
        chk32("t3_cause", bus.trap_cause, 32'h8000_0003);
        chk32("t3_rpc", bus.redirect_pc, 32'h0000_0200);
        bus.sw_int    = 1'b0;
        bus.timer_int = 1'b0;
        step();
        step();
        step();
        chk1("t3_stall_end", bus.stall_fetch, 1'b0);
        $display("txn sw trap: cause=%h", bus.trap_cause);

        // ---- masked sources never start a trap ----
        bus.timer_int = 1'b1;
        bus.mie_bits  = 32'h0000_0808;
        step();
        step();
        chk1("t4_mie_stall", bus.stall_fetch, 1'b0);
        chk1("t4_mie_te", bus.trap_enter, 1'b0);
        bus.mie_bits    = 32'h0000_0888;
        bus.mstatus_mie = 1'b0;
        step();
        step();
        chk1("t4_mstatus_stall", bus.stall_fetch, 1'b0);
        bus.timer_int   = 1'b0;
        bus.mstatus_mie = 1'b1;
        $display("txn masked: no trap");

        // ---- MRET and timer together: MRET first, then the trap ----
        bus.mtvec     = 32'h0000_0100;
        bus.mepc      = 32'h0000_2007;
        bus.next_pc   = 32'h0000_4000;
        bus.timer_int = 1'b1;
        bus.mret_req  = 1'b1;
        step();
        chk1("t5_drain_stall", bus.stall_fetch, 1'b1);
        step();
        chk1("t5_mc", bus.mret_commit, 1'b1);
        chk1("t5_te", bus.trap_enter, 1'b0);
        chk1("t5_rv", bus.redirect_valid, 1'b1);
        chk32("t5_rpc", bus.redirect_pc, 32'h0000_2004);
        chk1("t5_flush", bus.flush, 1'b1);
        bus.mret_req = 1'b0;
        step();
        chk1("t5_mc_drop", bus.mret_commit, 1'b0);
        step();
        chk1("t5_flush_te", bus.trap_enter, 1'b0);
        step();
        chk1("t5_idle_stall", bus.stall_fetch, 1'b0);
        step();
        chk1("t5_drain2_stall", bus.stall_fetch, 1'b1);
        step();
        chk1("t5_te2", bus.trap_enter, 1'b1);
        chk32("t5_cause2", bus.trap_cause, 32'h8000_0007);
        chk32("t5_epc2", bus.trap_epc, 32'h0000_4000);
        chk32("t5_rpc2", bus.redirect_pc, 32'h0000_0100);
        bus.timer_int = 1'b0;
        step();
        step();
        step();
        chk1("t5_stall_end", bus.stall_fetch, 1'b0);
        $display("txn mret then timer trap: rpc=%h", bus.redirect_pc);

        // ---- source drops during DRAIN: cancel ----
        bus.drain_done = 1'b0;
        bus.timer_int  = 1'b1;
        step();
        chk1("t6_stall", bus.stall_fetch, 1'b1);
        bus.timer_int = 1'b0;
        step();
        chk1("t6_wait_stall", bus.stall_fetch, 1'b1);
        bus.drain_done = 1'b1;
        step();
        chk1("t6_idle_stall", bus.stall_fetch, 1'b0);
        chk1("t6_te", bus.trap_enter, 1'b0);
        chk1("t6_rv", bus.redirect_valid, 1'b0);
        step();
        chk1("t6_te_late", bus.trap_enter, 1'b0);
        chk1("t6_rv_late", bus.redirect_valid, 1'b0);
        $display("txn cancelled trap");

        // ---- drain timeout ----
        bus.drain_done = 1'b0;
        bus.timer_int  = 1'b1;
        step();
        chk1("t7_stall", bus.stall_fetch, 1'b1);
        for (int i = 2; i <= 15; i++) begin
            step();
            chk1("t7_no_err", bus.drain_err, 1'b0);
        end
        step();
        chk1("t7_err", bus.drain_err, 1'b1);
        chk1("t7_err_stall", bus.stall_fetch, 1'b1);
        bus.timer_int = 1'b0;
        step();
        chk1("t7_err_drop", bus.drain_err, 1'b0);
        chk1("t7_stall_end", bus.stall_fetch, 1'b0);
        chk1("t7_te", bus.trap_enter, 1'b0);
        $display("txn drain timeout");

        // ---- reset during FLUSH ----
        bus.drain_done = 1'b1;
        bus.timer_int  = 1'b1;
        bus.next_pc    = 32'h0000_5008;
        step();
        step();
        chk1("t8_te", bus.trap_enter, 1'b1);
        step();
        chk1("t8_flush", bus.flush, 1'b1);
        reset         = 1'b1;
        bus.timer_int = 1'b0;
        #1;
        chk_all_zero("t8_async");
        step();
        chk_all_zero("t8_hold");
        reset = 1'b0;
        step();
        chk_all_zero("t8_rel1");
        step();
        chk_all_zero("t8_rel2");
        $display("txn reset during flush");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
